ada_if_stage: RTL and testbench

- Instruction Fetch stage; sits directly downstream of the IA/IF PC register.
- Takes the registered PC, runs a request/ready handshake with instruction memory, and drives the registered instruction, PC and valid to the IF/ID boundary.
- Generates if_stall back to the IA/IF register and absorbs memory wait states, downstream stalls and flushes. A flush arriving while a request is outstanding is aborted cleanly.

---
 rtl/ada_if_pkg.sv | 39 +++
 rtl/ada_if_hold_buffer.sv | 49 ++++
 rtl/ada_if_stage.sv | 166 ++++++++++++++++
 tb/tb_ada_if_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ada_if_pkg.sv
// ---------------------------------------------------------------------------
// ada_if_pkg
//   Shared types and constants for the instruction fetch stage.
//   - ADA_RESET_DEFAULT : reset value used for architectural PC registers
//   - ADA_NOP_INSTR     : bubble instruction driven whenever a slot is invalid
//   - if_state_e        : fetch FSM states (FETCH / HOLD / ABORT)
//   - if_slot_t         : one fetched instruction plus its PC and fault flags
// ---------------------------------------------------------------------------
package ada_if_pkg;

  localparam logic [31:0] ADA_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ADA_NOP_INSTR     = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    ABORT = 2'b10
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc_addr;
    logic        exc_bus;
  } if_slot_t;

  // Turn a slot into a bubble: NOP and no faults. The PC is left as-is since
  // it carries no meaning while the slot is invalid.
  function automatic if_slot_t make_bubble(input if_slot_t cur,
                                           input logic [31:0] nop);
    if_slot_t b;
    b          = cur;
    b.instr    = nop;
    b.exc_addr = 1'b0;
    b.exc_bus  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ada_if_hold_buffer.sv
// ---------------------------------------------------------------------------
// ada_if_hold_buffer
//   Single-entry skid register. Catches a completed fetch when ID is stalled
//   so the memory handshake can finish without losing the data.
//   Ports:
//     clk, rst_n  : clock, async active-low reset (clears the full flag)
//     load_i      : capture slot_i (takes priority over clear_i)
//     clear_i     : drop the entry (drained to the output or flushed)
//     slot_i      : fetched {instr, pc, exc_addr, exc_bus}
//     slot_o      : buffered entry
//     full_o      : entry is valid
// ---------------------------------------------------------------------------
module ada_if_hold_buffer
  import ada_if_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_i,
  input  logic     clear_i,
  input  if_slot_t slot_i,
  output if_slot_t slot_o,
  output logic     full_o
);

  logic     full_q;
  if_slot_t slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; full_q alone says whether it is
  // meaningful, so a reset here would only add fan-out on rst_n.
  always_ff @(posedge clk) begin
    if (load_i) begin
      slot_q <= slot_i;
    end
  end

  assign slot_o = slot_q;
  assign full_o = full_q;

endmodule

// File: rtl/ada_if_stage.sv
// ---------------------------------------------------------------------------
// ada_if_stage
//   Instruction fetch stage between the IA/IF PC register and IF/ID.
//   Runs a rd/ready handshake with instruction memory, absorbs wait states,
//   ID stalls and flushes, and registers the fetched instruction for ID.
//   Ports:
//     clk, rst            : clock, async active-low reset
//     pc_in               : PC from IA/IF
//     if_flush            : kill the fetch in progress and the output slot
//     id_stall            : ID cannot accept a new instruction
//     imem_addr/imem_rd   : word-aligned request, held until imem_ready
//     imem_data/ready/err : completion strobe with data and bus error
//     if_stall            : hold the IA/IF register
//     if_instruction/pc/valid, if_exc_addr, if_exc_bus : registered to ID
// ---------------------------------------------------------------------------
module ada_if_stage
  import ada_if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = ADA_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        if_flush,
  input  logic        id_stall,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        imem_error,
  output logic        if_stall,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_exc_addr,
  output logic        if_exc_bus
);

  if_state_e   state_q, state_d;
  logic        run_q;
  logic [31:0] req_addr_q, req_addr_d;
  if_slot_t    out_q, out_d;
  logic        valid_q, valid_d;

  logic        misalign;
  logic        done;
  logic        buf_load, buf_clear, buf_full;
  if_slot_t    fetch_slot, buf_slot;

  assign misalign = |pc_in[1:0];

  assign fetch_slot = '{
    instr:    misalign ? NOP_INSTR : imem_data,
    pc:       pc_in,
    exc_addr: misalign,
    exc_bus:  !misalign && imem_error
  };

  ada_if_hold_buffer u_hold_buffer (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .slot_i  (fetch_slot),
    .slot_o  (buf_slot),
    .full_o  (buf_full)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    valid_d    = valid_q;
    imem_rd    = 1'b0;
    imem_addr  = {pc_in[31:2], 2'b00};
    if_stall   = 1'b1;
    done       = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;

    unique case (state_q)
      FETCH: begin
        // run_q keeps the bus quiet for the partial cycle after reset release.
        imem_rd = run_q && !misalign;
        done    = run_q && (misalign || imem_ready);
        // pc_in is frozen by if_stall while waiting, so this holds the
        // address of the first request cycle.
        if (imem_rd) begin
          req_addr_d = imem_addr;
        end
        if (done) begin
          if (!id_stall) begin
            out_d    = fetch_slot;
            valid_d  = 1'b1;
            if_stall = 1'b0;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (!id_stall) begin
          out_d   = make_bubble(out_q, NOP_INSTR);
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (!id_stall && buf_full) begin
          out_d     = buf_slot;
          valid_d   = 1'b1;
          if_stall  = 1'b0;
          buf_clear = 1'b1;
          state_d   = FETCH;
        end
      end

      ABORT: begin
        // The bus request cannot be withdrawn; keep it up until it completes
        // and throw the data away.
        imem_rd   = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ready) begin
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    if (if_flush) begin
      if_stall  = 1'b0;
      out_d     = make_bubble(out_q, NOP_INSTR);
      valid_d   = 1'b0;
      buf_load  = 1'b0;
      buf_clear = 1'b1;
      state_d   = (imem_rd && !imem_ready) ? ABORT : FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      req_addr_q <= ADA_RESET_DEFAULT;
      out_q      <= '{instr: NOP_INSTR, pc: ADA_RESET_DEFAULT,
                      exc_addr: 1'b0, exc_bus: 1'b0};
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  assign if_instruction = out_q.instr;
  assign if_pc          = out_q.pc;
  assign if_valid       = valid_q;
  assign if_exc_addr    = out_q.exc_addr;
  assign if_exc_bus     = out_q.exc_bus;

endmodule

// File: tb/tb_ada_if_stage.sv
// ---------------------------------------------------------------------------
// tb_ada_if_stage
//   Directed, table-driven bench for ada_if_stage. Each table row gives the
//   inputs for one cycle, the expected combinational outputs in that cycle
//   and the expected registered outputs after the following rising edge.
//   Reset-mid-request is a hand-written sequence at the end.
// ---------------------------------------------------------------------------
module tb_ada_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        if_flush;
  logic        id_stall;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        imem_error;
  logic        if_stall;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_exc_addr;
  logic        if_exc_bus;

  int n_vec  = 0;
  int n_fail = 0;

  ada_if_stage #(.NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .if_flush       (if_flush),
    .id_stall       (id_stall),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_data      (imem_data),
    .imem_ready     (imem_ready),
    .imem_error     (imem_error),
    .if_stall       (if_stall),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .if_exc_addr    (if_exc_addr),
    .if_exc_bus     (if_exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        ids;
    logic [31:0] pc;
    logic        rdy;
    logic        err;
    logic [31:0] data;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_xa;
    logic        e_xb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic flush, input logic ids,
                              input logic [31:0] pc, input logic rdy,
                              input logic err, input logic [31:0] data,
                              input logic e_rd, input logic [31:0] e_addr,
                              input logic e_stall, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic e_xa, input logic e_xb);
    vec_t v;
    v.flush = flush;   v.ids = ids;       v.pc = pc;
    v.rdy = rdy;       v.err = err;       v.data = data;
    v.e_rd = e_rd;     v.e_addr = e_addr; v.e_stall = e_stall;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_xa = e_xa;     v.e_xb = e_xb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic apply(input int idx, input vec_t v);
    if_flush   = v.flush;
    id_stall   = v.ids;
    pc_in      = v.pc;
    imem_ready = v.rdy;
    imem_error = v.err;
    imem_data  = v.data;
    #1;
    check($sformatf("v%0d imem_rd", idx), 32'(imem_rd), 32'(v.e_rd));
    check($sformatf("v%0d if_stall", idx), 32'(if_stall), 32'(v.e_stall));
    if (v.e_rd)
      check($sformatf("v%0d imem_addr", idx), imem_addr, v.e_addr);
    @(posedge clk);
    #1;
    check($sformatf("v%0d if_valid", idx), 32'(if_valid), 32'(v.e_valid));
    check($sformatf("v%0d if_instruction", idx), if_instruction, v.e_instr);
    check($sformatf("v%0d if_exc_addr", idx), 32'(if_exc_addr), 32'(v.e_xa));
    check($sformatf("v%0d if_exc_bus", idx), 32'(if_exc_bus), 32'(v.e_xb));
    if (v.e_valid)
      check($sformatf("v%0d if_pc", idx), if_pc, v.e_pc);
    @(negedge clk);
  endtask

  initial begin
    int waited;

    //            fl    ids   pc            rdy   err   data          rd    addr          stl   val   instr         pc            xa    xb
    // First cycle after reset release: no request yet.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    // Zero-wait memory: one instruction per cycle.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'hA000_0000, 1'b1, 32'h0,        1'b0, 1'b1, 32'hA000_0000, 32'h0,       1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'hA000_0004, 1'b1, 32'h4,        1'b0, 1'b1, 32'hA000_0004, 32'h4,       1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'hA000_0008, 1'b1, 32'h8,        1'b0, 1'b1, 32'hA000_0008, 32'h8,       1'b0, 1'b0));
    // Three wait states at 0x100.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'hB000_0100, 1'b1, 32'h100,      1'b0, 1'b1, 32'hB000_0100, 32'h100,     1'b0, 1'b0));
    // Ready while ID stalled for two cycles: HOLD, outputs frozen.
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'hC000_0104, 1'b1, 32'h104,      1'b1, 1'b1, 32'hB000_0100, 32'h100,     1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 1'b1, 32'hB000_0100, 32'h100,     1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1, 32'hC000_0104, 32'h104,     1'b0, 1'b0));
    // Flush on second wait cycle of 0x200, target 0x300: abort then refetch.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,      1'b0, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0300, 1'b1, 1'b0, 32'hDEAD_0200, 1'b1, 32'h200,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0300, 1'b1, 1'b0, 32'hD000_0300, 1'b1, 32'h300,      1'b0, 1'b1, 32'hD000_0300, 32'h300,     1'b0, 1'b0));
    // Misaligned PC: no request, address exception with NOP.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0102, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1, NOP,          32'h102,      1'b1, 1'b0));
    // Bus error, then a clean fetch clears the flag.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0104, 1'b1, 1'b1, 32'hE000_0104, 1'b1, 32'h104,      1'b0, 1'b1, 32'hE000_0104, 32'h104,     1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0108, 1'b1, 1'b0, 32'hE000_0108, 1'b1, 32'h108,      1'b0, 1'b1, 32'hE000_0108, 32'h108,     1'b0, 1'b0));
    // Flush coinciding with ready: data dropped, straight back to FETCH.
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_010C, 1'b1, 1'b0, 32'hF000_010C, 1'b1, 32'h10C,      1'b0, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'h4000_0400, 1'b1, 32'h400,      1'b0, 1'b1, 32'h4000_0400, 32'h400,     1'b0, 1'b0));
    // Flush while in HOLD with ID stalled: slot cleared, buffer discarded.
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0404, 1'b1, 1'b0, 32'h4000_0404, 1'b1, 32'h404,      1'b1, 1'b1, 32'h4000_0400, 32'h400,     1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0404, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0500, 1'b1, 1'b0, 32'h5000_0500, 1'b1, 32'h500,      1'b0, 1'b1, 32'h5000_0500, 32'h500,     1'b0, 1'b0));
    // Second flush while already in ABORT: stays in ABORT on the old address.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0600, 1'b0, 1'b0, 32'h0,         1'b1, 32'h600,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0600, 1'b0, 1'b0, 32'h0,         1'b1, 32'h600,      1'b0, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0700, 1'b0, 1'b0, 32'h0,         1'b1, 32'h600,      1'b0, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0800, 1'b1, 1'b0, 32'hDEAD_0600, 1'b1, 32'h600,      1'b1, 1'b0, NOP,          32'h0,        1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0800, 1'b1, 1'b0, 32'h8000_0800, 1'b1, 32'h800,      1'b0, 1'b1, 32'h8000_0800, 32'h800,     1'b0, 1'b0));
    // Wait state with ID stalled: outputs hold instead of bubbling.
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0804, 1'b0, 1'b0, 32'h0,         1'b1, 32'h804,      1'b1, 1'b1, 32'h8000_0800, 32'h800,     1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0804, 1'b1, 1'b0, 32'h8000_0804, 1'b1, 32'h804,      1'b0, 1'b1, 32'h8000_0804, 32'h804,     1'b0, 1'b0));

    // Reset state.
    rst        = 1'b0;
    pc_in      = 32'h0;
    if_flush   = 1'b0;
    id_stall   = 1'b0;
    imem_data  = 32'h0;
    imem_ready = 1'b0;
    imem_error = 1'b0;
    #1;
    check("reset imem_rd", 32'(imem_rd), 32'd0);
    check("reset if_valid", 32'(if_valid), 32'd0);
    check("reset if_instruction", if_instruction, NOP);
    check("reset if_pc", if_pc, 32'h0);
    check("reset if_exc_addr", 32'(if_exc_addr), 32'd0);
    check("reset if_exc_bus", 32'(if_exc_bus), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset asserted mid-request drops rd and valid immediately.
    pc_in      = 32'h0000_0900;
    imem_ready = 1'b0;
    id_stall   = 1'b0;
    if_flush   = 1'b0;
    #1;
    check("pre-reset imem_rd", 32'(imem_rd), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset imem_rd", 32'(imem_rd), 32'd0);
    check("async reset if_valid", 32'(if_valid), 32'd0);
    check("async reset if_instruction", if_instruction, NOP);
    @(negedge clk);
    pc_in = 32'h0000_0A00;
    rst   = 1'b1;
    #1;
    check("release cycle imem_rd", 32'(imem_rd), 32'd0);
    // Bounded wait for the first request after release; expected next cycle.
    waited = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (imem_rd) break;
      waited++;
    end
    check("post-reset request latency", 32'(waited), 32'd0);
    check("post-reset imem_rd", 32'(imem_rd), 32'd1);
    check("post-reset imem_addr", imem_addr, 32'h0000_0A00);
    @(negedge clk);
    imem_ready = 1'b1;
    imem_data  = 32'hA000_0A00;
    @(posedge clk);
    #1;
    check("post-reset if_valid", 32'(if_valid), 32'd1);
    check("post-reset if_pc", if_pc, 32'h0000_0A00);
    check("post-reset if_instruction", if_instruction, 32'hA000_0A00);
    imem_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
